// File: rtl/seg_signed_n_if.sv
// -----------------------------------------------------------------------------
// seg_signed_n_if
//   Valid/ready request channel plus result channel for the signed
//   binary-to-7-segment converter.
//
//   Parameters
//     W   : two's-complement input width
//     ND  : number of decimal digits shown (sign byte comes on top)
//
//   Signals
//     in_valid  : master -> slave, x is presented
//     in_ready  : slave -> master, converter can take x this cycle
//     x         : master -> slave, signed value to show
//     out_valid : slave -> master, one-cycle pulse, o_seg just updated
//     o_seg     : slave -> master, active-low segment bytes, byte ND = sign
// -----------------------------------------------------------------------------
interface seg_signed_n_if #(
  parameter int W  = 8,
  parameter int ND = 3
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            x;
  logic                    out_valid;
  logic [8*(ND+1)-1:0]     o_seg;

  modport master (
    output in_valid,
    output x,
    input  in_ready,
    input  out_valid,
    input  o_seg
  );

  modport slave (
    input  in_valid,
    input  x,
    output in_ready,
    output out_valid,
    output o_seg
  );

endinterface

// File: rtl/seg_signed_n.sv
// -----------------------------------------------------------------------------
// seg_signed_n
//   Converts a signed two's-complement value into active-low 7-segment bytes:
//   ND decimal digits (byte 0 = units) and a sign byte at byte ND.
//   The magnitude is converted with a sequential shift-add-3 (double dabble),
//   one bit per clock, so a result takes W+2 cycles from IDLE back to IDLE.
//
//   Parameters
//     W        : input width (>= 2)
//     ND       : decimal digits, 10**ND must exceed 2**(W-1)
//     BLANK_LZ : 1 = blank leading zero digits (units digit always shown)
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : slave side of seg_signed_n_if (in_valid/in_ready/x in,
//            out_valid/o_seg out); its W/ND must match this module's.
//
//   Segment byte layout: bit7..bit0 = a,b,c,d,e,f,g,dp (0 = lit), dp unused.
// -----------------------------------------------------------------------------
module seg_signed_n #(
  parameter int W        = 8,
  parameter int ND       = 3,
  parameter int BLANK_LZ = 0
) (
  input  logic             clk,
  input  logic             rst,
  seg_signed_n_if.slave    bus
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (W < 2) begin : g_bad_w
    $error("seg_signed_n: W must be at least 2");
  end

  if ((10 ** ND) <= (2 ** (W - 1))) begin : g_bad_nd
    $error("seg_signed_n: ND digits cannot hold 2**(W-1)");
  end

  // ---------------------------------------------------------------------------
  // Local constants and types
  // ---------------------------------------------------------------------------
  localparam int CW = $clog2(W + 1);   // bit counter width
  localparam int BW = 4 * ND;          // BCD register width
  localparam int SW = 8 * (ND + 1);    // segment output width

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hFD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          state;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [SW-1:0]   o_seg_q;
  logic            sign_q;       // captured x[W-1]
  logic [W-1:0]    mag_q;        // |x| as unsigned, shifted out MSB first
  logic [BW-1:0]   bcd_q;        // packed BCD digits, digit 0 in [3:0]
  logic [CW-1:0]   cnt_q;        // bits already shifted in CONV

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [W-1:0]    x_abs;
  logic [BW-1:0]   bcd_adj;
  logic [SW-1:0]   seg_next;
  logic            lead_zero;

  // Decimal digit -> active-low segment pattern.
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Two's-complement negate in W bits. For x = -2**(W-1) the result is
  // 2**(W-1), which still fits because mag_q is read as unsigned.
  always_comb begin
    x_abs = bus.x[W-1] ? (~bus.x + W'(1)) : bus.x;
  end

  // Shift-add-3 correction: any digit >= 5 would become >= 10 after the
  // doubling shift, so pre-add 3 to make the shift carry into the next digit.
  always_comb begin
    // NOTE: every variable driven here gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    bcd_adj = bcd_q;
    for (int i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment image of the finished conversion. Scans from the top digit down;
  // lead_zero stays set while every digit seen so far is zero.
  always_comb begin
    seg_next  = '1;
    lead_zero = 1'b1;
    for (int k = ND - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        lead_zero = 1'b0;
      end
      if ((BLANK_LZ != 0) && lead_zero && (k != 0)) begin
        seg_next[8*k +: 8] = SEG_BLANK;
      end else begin
        seg_next[8*k +: 8] = digit_seg(bcd_q[4*k +: 4]);
      end
    end
    // Minus only for a nonzero magnitude; a zero BCD result means x was 0.
    seg_next[8*ND +: 8] = (sign_q && (bcd_q != '0)) ? SEG_MINUS : SEG_BLANK;
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs
  // ---------------------------------------------------------------------------
  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      o_seg_q     <= '1;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sign_q     <= bus.x[W-1];
            mag_q      <= x_abs;
            bcd_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= CONV;
          end
        end

        CONV: begin
          // Corrected digits and magnitude shift left as one long register;
          // the magnitude MSB enters BCD digit 0.
          {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
          cnt_q          <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          // o_seg only ever changes here, so it is steady through CONV/DONE.
          o_seg_q     <= seg_next;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          in_ready_q <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.o_seg     = o_seg_q;

endmodule

// File: tb/tb_seg_signed_n.sv
// -----------------------------------------------------------------------------
// tb_seg_signed_n
//   Three converters side by side: W=8/ND=3 with and without leading-zero
//   blanking, and a W=4/ND=1 build. Expected segment images come from a
//   decimal reference model (integer divide/modulo plus a digit table).
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
//   Latency is counted in edges after the accept edge: W+1 edges, i.e. the
//   out_valid edge is edge W+2 when the accept edge is counted as edge 1.
// -----------------------------------------------------------------------------
module tb_seg_signed_n;

  logic clk;
  logic rst;

  int checks;
  int errors;

  localparam logic [7:0] SEG_TAB [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                          8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  seg_signed_n_if #(.W(8), .ND(3)) b0 ();
  seg_signed_n_if #(.W(8), .ND(3)) b1 ();
  seg_signed_n_if #(.W(4), .ND(1)) b4 ();

  seg_signed_n #(.W(8), .ND(3), .BLANK_LZ(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  seg_signed_n #(.W(8), .ND(3), .BLANK_LZ(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  seg_signed_n #(.W(4), .ND(1), .BLANK_LZ(0)) u4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [15:0] s4;
    int          lat0;
    int          lat1;
    int          lat4;
    bit          stable;
  } res_t;

  // Reference: decimal digits of |v|, optional leading-zero blanking above
  // the most significant nonzero digit, sign byte at byte nd.
  function automatic logic [31:0] model_seg(input int v, input int nd, input bit blank);
    int m;
    int dig;
    int msd;
    logic [31:0] r;
    r   = '1;
    msd = 0;
    m   = (v < 0) ? -v : v;
    for (int k = 0; k < nd; k++) begin
      dig = m % 10;
      m   = m / 10;
      if (dig != 0) msd = k;
      r[8*k +: 8] = SEG_TAB[dig];
    end
    if (blank) begin
      for (int k = 1; k < nd; k++) begin
        if (k > msd) r[8*k +: 8] = 8'hFF;
      end
    end
    r[8*nd +: 8] = (v < 0) ? 8'hFD : 8'hFF;
    return r;
  endfunction

  function automatic int s8(input logic [7:0] v);
    logic signed [7:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int s4(input logic [3:0] v);
    logic signed [3:0] t;
    t = v;
    return int'(t);
  endfunction

  // One conversion on all three converters. Entered and left 1 unit after a
  // rising edge. x is scrambled right after the accept edge.
  task automatic run_one(input logic [7:0] v, output res_t r);
    logic [31:0] p0, p1;
    logic [15:0] p4;
    bit g0, g1, g4;
    r.s0 = '0; r.s1 = '0; r.s4 = '0;
    r.lat0 = -1; r.lat1 = -1; r.lat4 = -1;
    r.stable = 1'b1;
    g0 = 0; g1 = 0; g4 = 0;
    p0 = b0.o_seg; p1 = b1.o_seg; p4 = b4.o_seg;
    b0.x = v; b1.x = v; b4.x = v[3:0];
    b0.in_valid = 1'b1; b1.in_valid = 1'b1; b4.in_valid = 1'b1;
    @(posedge clk); #1;
    b0.in_valid = 1'b0; b1.in_valid = 1'b0; b4.in_valid = 1'b0;
    b0.x = 8'($urandom); b1.x = 8'($urandom); b4.x = 4'($urandom);
    for (int e = 1; e <= 40 && !(g0 && g1 && g4); e++) begin
      if (!g0 && b0.o_seg !== p0) r.stable = 1'b0;
      if (!g1 && b1.o_seg !== p1) r.stable = 1'b0;
      if (!g4 && b4.o_seg !== p4) r.stable = 1'b0;
      @(posedge clk); #1;
      if (!g0 && b0.out_valid) begin g0 = 1; r.lat0 = e; r.s0 = b0.o_seg; end
      if (!g1 && b1.out_valid) begin g1 = 1; r.lat1 = e; r.s1 = b1.o_seg; end
      if (!g4 && b4.out_valid) begin g4 = 1; r.lat4 = e; r.s4 = b4.o_seg; end
    end
  endtask

  task automatic test_reset();
    // Checked while rst is still asserted, then again after release.
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1 || b4.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready pass %0d: got %b%b%b expected 111", pass,
                 b0.in_ready, b1.in_ready, b4.in_ready);
      end
      checks++;
      if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid pass %0d: got %b%b%b expected 000", pass,
                 b0.out_valid, b1.out_valid, b4.out_valid);
      end
      checks++;
      if (b0.o_seg !== 32'hFFFF_FFFF || b1.o_seg !== 32'hFFFF_FFFF || b4.o_seg !== 16'hFFFF) begin
        errors++;
        $display("FAIL reset_o_seg pass %0d: got %h %h %h expected all FF", pass,
                 b0.o_seg, b1.o_seg, b4.o_seg);
      end
      if (pass == 0) begin
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0]  tv [7];
    logic [31:0] e0 [7];
    logic [31:0] e1 [7];
    res_t r;
    tv = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'hFB, 8'h0A, 8'h2A};
    e0 = '{32'hFD9F2501, 32'hFF9F251F, 32'hFD03039F, 32'hFF030303,
           32'hFD030349, 32'hFF039F03, 32'hFF039925};
    e1 = '{32'hFD9F2501, 32'hFF9F251F, 32'hFDFFFF9F, 32'hFFFFFF03,
           32'hFDFFFF49, 32'hFFFF9F03, 32'hFFFF9925};
    for (int i = 0; i < 7; i++) begin
      run_one(tv[i], r);
      checks++;
      if (r.lat0 !== 9 || r.lat1 !== 9) begin
        errors++;
        $display("FAIL directed_latency x=%h: got %0d/%0d expected 9", tv[i], r.lat0, r.lat1);
      end
      checks++;
      if (r.s0 !== e0[i]) begin
        errors++;
        $display("FAIL directed_seg_nblank x=%h: got %h expected %h", tv[i], r.s0, e0[i]);
      end
      checks++;
      if (r.s1 !== e1[i]) begin
        errors++;
        $display("FAIL directed_seg_blank x=%h: got %h expected %h", tv[i], r.s1, e1[i]);
      end
      checks++;
      if (!r.stable) begin
        errors++;
        $display("FAIL directed_hold x=%h: o_seg moved during conversion expected steady", tv[i]);
      end
    end
  endtask

  task automatic test_w4();
    res_t r;
    run_one(8'h08, r);
    checks++;
    if (r.s4 !== 16'hFD01) begin
      errors++;
      $display("FAIL w4_min: got %h expected fd01", r.s4);
    end
    checks++;
    if (r.lat4 !== 5) begin
      errors++;
      $display("FAIL w4_latency: got %0d expected 5", r.lat4);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    bit   pulsed;
    b0.x = 8'h05; b0.in_valid = 1'b1;
    @(posedge clk); #1;                // accept edge
    b0.in_valid = 1'b0; b0.x = 8'($urandom);
    @(posedge clk); #1;                // CONV cycle 2
    @(posedge clk); #1;                // CONV cycle 3
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b0.o_seg !== 32'hFFFF_FFFF || b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got seg=%h rdy=%b ov=%b expected ffffffff 1 0",
               b0.o_seg, b0.in_ready, b0.out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulsed = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (b0.out_valid) pulsed = 1;
    end
    checks++;
    if (pulsed || b0.in_ready !== 1'b1 || b0.o_seg !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mid_quiet: got pulse=%b rdy=%b seg=%h expected 0 1 ffffffff",
               pulsed, b0.in_ready, b0.o_seg);
    end
    // Release, then present x at the very first edge.
    rst = 1'b1;
    #2 rst = 1'b0;
    run_one(8'h2A, r);
    checks++;
    if (r.lat0 !== 9 || r.s0 !== 32'hFF039925) begin
      errors++;
      $display("FAIL reset_mid_next: got lat=%0d seg=%h expected 9 ff039925", r.lat0, r.s0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  acc_x;
    logic [31:0] last0, last1, exp0, exp1;
    bit          exp_pulse;
    int          pulses;
    pulses = 0;
    acc_x  = '0;
    last0  = b0.o_seg;
    last1  = b1.o_seg;
    b0.x = 8'($urandom); b1.x = b0.x;
    b0.in_valid = 1'b1; b1.in_valid = 1'b1;
    for (int e = 0; e < 60; e++) begin
      if (e % 10 == 0) acc_x = b0.x;   // predicted accept edges
      @(posedge clk); #1;
      exp_pulse = (e % 10 == 9);
      checks++;
      if (b0.out_valid !== exp_pulse || b1.out_valid !== exp_pulse) begin
        errors++;
        $display("FAIL b2b_pulse edge %0d: got %b%b expected %b%b", e,
                 b0.out_valid, b1.out_valid, exp_pulse, exp_pulse);
      end
      if (exp_pulse) begin
        pulses++;
        exp0 = model_seg(s8(acc_x), 3, 1'b0);
        exp1 = model_seg(s8(acc_x), 3, 1'b1);
        checks++;
        if (b0.o_seg !== exp0 || b1.o_seg !== exp1 || b0.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_value x=%h: got %h %h rdy=%b expected %h %h 1",
                   acc_x, b0.o_seg, b1.o_seg, b0.in_ready, exp0, exp1);
        end
        last0 = exp0;
        last1 = exp1;
      end else begin
        checks++;
        if (b0.o_seg !== last0 || b1.o_seg !== last1) begin
          errors++;
          $display("FAIL b2b_hold edge %0d: got %h %h expected %h %h",
                   e, b0.o_seg, b1.o_seg, last0, last1);
        end
      end
      b0.x = 8'($urandom); b1.x = b0.x;
    end
    b0.in_valid = 1'b0; b1.in_valid = 1'b0;
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 6", pulses);
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  v;
    logic [31:0] m4;
    res_t        r;
    int          start;
    start = int'($urandom_range(255, 0));
    for (int i = 0; i < 256; i++) begin
      v = 8'(start + i);
      run_one(v, r);
      m4 = model_seg(s4(v[3:0]), 1, 1'b0);
      checks++;
      if (r.s0 !== model_seg(s8(v), 3, 1'b0)) begin
        errors++;
        $display("FAIL sweep_nblank x=%h: got %h expected %h", v, r.s0, model_seg(s8(v), 3, 1'b0));
      end
      checks++;
      if (r.s1 !== model_seg(s8(v), 3, 1'b1)) begin
        errors++;
        $display("FAIL sweep_blank x=%h: got %h expected %h", v, r.s1, model_seg(s8(v), 3, 1'b1));
      end
      checks++;
      if (r.s4 !== m4[15:0]) begin
        errors++;
        $display("FAIL sweep_w4 x=%h: got %h expected %h", v[3:0], r.s4, m4[15:0]);
      end
      checks++;
      if (r.lat0 !== 9 || r.lat1 !== 9 || r.lat4 !== 5) begin
        errors++;
        $display("FAIL sweep_latency x=%h: got %0d/%0d/%0d expected 9/9/5",
                 v, r.lat0, r.lat1, r.lat4);
      end
      checks++;
      if (!r.stable) begin
        errors++;
        $display("FAIL sweep_hold x=%h: o_seg moved during conversion expected steady", v);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b0.in_valid = 1'b0; b1.in_valid = 1'b0; b4.in_valid = 1'b0;
    b0.x = '0; b1.x = '0; b4.x = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_w4();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_signed_n.md
SEG_SIGNED_N -- requirements
Module: seg_signed_n

Interface
REQ-001 SHALL have parameter W, default 8: input two's-complement width, W >= 2.
REQ-002 SHALL have parameter ND, default 3: decimal digit count, 10^ND > 2^(W-1) required, checked at elaboration.
REQ-003 SHALL have parameter BLANK_LZ, default 0: 1 = blank leading zero digits.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  in  1  x is presented.
REQ-007 SHALL have port in_ready  out  1  block can accept x.
REQ-008 SHALL have port x  in  W  signed two's-complement value.
REQ-009 SHALL have port out_valid  out  1  one-cycle pulse; o_seg just updated.
REQ-010 SHALL have port o_seg  out  8*(ND+1)  segment bytes, active-low; byte k (bits 8k+7:8k) = decimal digit k (k=0 units); byte ND = sign.

Function
REQ-011 SHALL use per-byte bit order a,b,c,d,e,f,g,dp (bit7..bit0); active-low bytes: 0=03,1=9F,2=25,3=0D,4=99,5=49,6=41,7=1F,8=01,9=09, blank=FF, minus=FD; dp always off.
REQ-012 SHALL accept x on a rising edge where in_valid && in_ready (accept edge).
REQ-013 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-014 SHALL, on accept, register the sign x[W-1] and the magnitude |x| as a W-bit unsigned value; x = -2^(W-1) SHALL give magnitude 2^(W-1) without overflow.
REQ-015 SHALL convert the magnitude by shift-add-3 (double dabble), one bit per cycle: W cycles in CONV, MSB first, via a W-count counter.
REQ-016 SHALL, in each CONV cycle, add 3 to every BCD nibble >= 5 before the shift.
REQ-017 SHALL spend exactly one cycle in DONE, then register o_seg and set out_valid = 1 on the edge that leaves DONE.
REQ-018 SHALL have an accept-to-out_valid latency of W+2 rising edges, with out_valid high for exactly one cycle.
REQ-019 SHALL assert in_ready in the same cycle as out_valid, so back-to-back accepts are legal; throughput is one result per W+2 cycles.
REQ-020 SHALL hold o_seg stable between updates; o_seg SHALL NOT change during CONV or DONE.
REQ-021 SHALL drive the sign byte to minus when the sign is 1 and the magnitude is nonzero, and to blank otherwise (sign fixed at byte ND).
REQ-022 SHALL, when BLANK_LZ=1, blank each digit above the most-significant nonzero digit; byte 0 is never blanked (value 0 shows "0").
REQ-023 SHALL, when BLANK_LZ=0, show every digit, including leading zeros.
REQ-024 SHALL ignore in_valid while in CONV or DONE, with no sampling or side effects.
REQ-025 SHALL NOT need x to stay stable after the accept edge.

Reset
REQ-026 SHALL, when rst=1 at any time (including mid-CONV), asynchronously force: state IDLE, in_ready=1, out_valid=0, o_seg all FF, counter and BCD registers 0.
REQ-027 SHALL, after rst deasserts, accept on the first qualifying edge with no extra idle cycle required.

Verification (W=8, ND=3; o_seg listed byte3..byte0)
REQ-028 SHALL verify: BLANK_LZ=0, x=8'h80 accepted -> out_valid pulses at edge 10 after accept; o_seg = FD,9F,25,01 (-128).
REQ-029 SHALL verify: BLANK_LZ=0, x=8'h7F -> o_seg = FF,9F,25,1F (+127); x=8'hFF -> FD,03,03,9F (-1).
REQ-030 SHALL verify: BLANK_LZ=1, x=8'h00 -> FF,FF,FF,03; x=8'hFB -> FD,FF,FF,49 (-5); x=8'h0A -> FF,FF,9F,03 (10).
REQ-031 SHALL verify: x=8'h05 accepted, then rst pulsed on the 3rd CONV cycle -> o_seg=FF..FF, out_valid never pulses, in_ready=1; next x=8'h2A -> FF,03,99,25 (42).
REQ-032 SHALL verify: in_valid held high with x changing every cycle -> only values present on accept edges are converted, one out_valid per 10 cycles, o_seg unchanged between pulses.
REQ-033 SHALL verify: exhaustive sweep over x = -128..127 against a reference model, both BLANK_LZ values, plus one W=4/ND=1 build where x=4'h8 -> FD,01.
